// File: rtl/proc_imul_iter_unit.sv
// -----------------------------------------------------------------------------
// proc_imul_iter_unit
//
// Iterative integer multiplier for the X stage. Returns the low p_nbits of a*b,
// which is the same bit pattern for signed and unsigned operands. Each CALC
// step either adds the multiplicand (when b[0] is set) and shifts by one, or
// skips a run of trailing zeros in b (up to p_max_skip bits at once). At most
// one operation is in flight; val/rdy handshakes on request and response.
//
// Parameters:
//   p_nbits     operand/result width (2..64)
//   p_max_skip  max zero bits of b consumed in one step (1..p_nbits)
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   req_val    request valid
//   req_rdy    unit idle and able to accept a request
//   req_a      multiplicand
//   req_b      multiplier
//   resp_val   result valid (held until resp_rdy)
//   resp_rdy   consumer accepts the result
//   resp_data  (a*b) mod 2^p_nbits
//   busy       unit is not idle
//
// Build option:
//   PROC_IMUL_FIXED_LAT_EN  when defined, every step consumes exactly one bit
//                           and b==0 is not short-cut, so every operation takes
//                           exactly p_nbits CALC steps.
// -----------------------------------------------------------------------------
module proc_imul_iter_unit #(
  parameter int p_nbits    = 32,
  parameter int p_max_skip = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_data,
  output logic               busy
);

  localparam int CW = $clog2(p_nbits + 1);

  localparam logic [CW-1:0]      ONE_C    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      NBITS_C  = CW'(p_nbits);
  localparam logic [p_nbits-1:0] ZERO_W_C = {p_nbits{1'b0}};
  localparam logic [CW-1:0]      ZERO_C_C = {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_next_s;
  logic [p_nbits-1:0] a_r, a_next_s;
  logic [p_nbits-1:0] b_r, b_next_s;
  logic [p_nbits-1:0] acc_r, acc_next_s;
  logic [CW-1:0]      cnt_r, cnt_next_s;

  logic [CW-1:0]      step_s;
  logic [p_nbits-1:0] b_shift_s;
  logic [CW-1:0]      cnt_upd_s;
  logic               exit_s;

`ifndef PROC_IMUL_FIXED_LAT_EN
  localparam logic [CW-1:0] MAX_SKIP_C = CW'(p_max_skip);

  logic [CW-1:0] tz_s;
  logic [CW-1:0] tz_cap_s;
  logic [CW-1:0] rem_s;

  // Trailing-zero count of v; returns p_nbits when v is zero.
  function automatic logic [CW-1:0] tz_f(input logic [p_nbits-1:0] v);
    logic          found;
    logic [CW-1:0] n;
    found = 1'b0;
    n     = {CW{1'b0}};
    for (int i = 0; i < p_nbits; i++) begin
      if (found) begin
        found = 1'b1;
      end else if (v[i]) begin
        found = 1'b1;
      end else begin
        n = n + ONE_C;
      end
    end
    return n;
  endfunction
`endif

  // Step size for the current CALC cycle.
  always_comb begin
    step_s = ONE_C;
`ifdef PROC_IMUL_FIXED_LAT_EN
    step_s = ONE_C;
`else
    tz_s     = tz_f(b_r);
    rem_s    = NBITS_C - cnt_r;
    tz_cap_s = (tz_s > MAX_SKIP_C) ? MAX_SKIP_C : tz_s;
    if (b_r[0]) begin
      step_s = ONE_C;
    end else begin
      // Never step past the remaining bit budget of the operand.
      step_s = (tz_cap_s > rem_s) ? rem_s : tz_cap_s;
    end
`endif
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next_s = state_r;
    a_next_s     = a_r;
    b_next_s     = b_r;
    acc_next_s   = acc_r;
    cnt_next_s   = cnt_r;
    b_shift_s    = b_r >> step_s;
    cnt_upd_s    = cnt_r + step_s;
    exit_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (req_val) begin
          a_next_s   = req_a;
          b_next_s   = req_b;
          acc_next_s = ZERO_W_C;
          cnt_next_s = ZERO_C_C;
`ifdef PROC_IMUL_FIXED_LAT_EN
          state_next_s = ST_CALC;
`else
          state_next_s = (req_b == ZERO_W_C) ? ST_DONE : ST_CALC;
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_CALC: begin
        if (b_r[0]) begin
          acc_next_s = acc_r + a_r;
        end else begin
          acc_next_s = acc_r;
        end
        a_next_s   = a_r << step_s;
        b_next_s   = b_shift_s;
        cnt_next_s = cnt_upd_s;
`ifdef PROC_IMUL_FIXED_LAT_EN
        exit_s = (cnt_upd_s >= NBITS_C);
`else
        exit_s = (b_shift_s == ZERO_W_C) || (cnt_upd_s >= NBITS_C);
`endif
        state_next_s = exit_s ? ST_DONE : ST_CALC;
      end

      ST_DONE: begin
        if (resp_rdy) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      a_r     <= ZERO_W_C;
      b_r     <= ZERO_W_C;
      acc_r   <= ZERO_W_C;
      cnt_r   <= ZERO_C_C;
    end else begin
      state_r <= state_next_s;
      a_r     <= a_next_s;
      b_r     <= b_next_s;
      acc_r   <= acc_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Outputs decode the state register; reset masks them so they read zero
  // for the whole time reset is asserted, including its first cycle.
  assign req_rdy   = (state_r == ST_IDLE) && !reset;
  assign resp_val  = (state_r == ST_DONE) && !reset;
  assign busy      = (state_r != ST_IDLE) && !reset;
  assign resp_data = reset ? ZERO_W_C : acc_r;

endmodule

// File: tb/tb_proc_imul_iter_unit.sv
module tb_proc_imul_iter_unit;

`ifdef PROC_IMUL_FIXED_LAT_EN
  localparam bit FIXED_LAT = 1'b1;
`else
  localparam bit FIXED_LAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_data;
  logic        busy;

  logic        n_req_val;
  logic        n_req_rdy;
  logic [7:0]  n_req_a;
  logic [7:0]  n_req_b;
  logic        n_resp_val;
  logic        n_resp_rdy;
  logic [7:0]  n_resp_data;
  logic        n_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_imul_iter_unit #(.p_nbits(32), .p_max_skip(4)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .busy(busy)
  );

  proc_imul_iter_unit #(.p_nbits(8), .p_max_skip(3)) dut8 (
    .clk(clk), .reset(reset),
    .req_val(n_req_val), .req_rdy(n_req_rdy), .req_a(n_req_a), .req_b(n_req_b),
    .resp_val(n_resp_val), .resp_rdy(n_resp_rdy), .resp_data(n_resp_data),
    .busy(n_busy)
  );

  // ---- stimulus helpers (no comparisons inside) ----
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, output bit ok);
    int w;
    w = 0;
    while (!req_rdy && w < 100) begin
      @(posedge clk); #1; w++;
    end
    ok = req_rdy;
    req_val = 1'b1; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_val = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678;
  endtask

  task automatic wait_resp32(output int lat);
    lat = 1;
    while (!resp_val && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic pulse_rdy32();
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, output bit ok);
    int w;
    w = 0;
    while (!n_req_rdy && w < 100) begin
      @(posedge clk); #1; w++;
    end
    ok = n_req_rdy;
    n_req_val = 1'b1; n_req_a = a; n_req_b = b;
    @(posedge clk); #1;
    n_req_val = 1'b0; n_req_a = 8'h5A; n_req_b = 8'hA5;
  endtask

  task automatic wait_resp8(output int lat);
    lat = 1;
    while (!n_resp_val && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({req_rdy, resp_val, busy} !== 3'b000 || resp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy/val/busy=%b data=%h, required 000 data=0",
               {req_rdy, resp_val, busy}, resp_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_rdy !== 1'b1 || busy !== 1'b0 || n_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: req_rdy=%b busy=%b n_req_rdy=%b, required 1 0 1",
               req_rdy, busy, n_req_rdy);
    end
  endtask

  task automatic test_zero_b();
    bit ok; int lat;
    issue32(32'd3, 32'd0, ok);
    wait_resp32(lat);
    checks++;
    if (!ok || lat != (FIXED_LAT ? 33 : 1) || resp_data !== 32'd0) begin
      errors++;
      $display("FAIL zero_b: ok=%0d lat=%0d data=%0d, required lat=%0d data=0",
               ok, lat, resp_data, FIXED_LAT ? 33 : 1);
    end
    pulse_rdy32();
    checks++;
    if (busy !== 1'b0 || req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      errors++;
      $display("FAIL zero_b_idle: busy=%b req_rdy=%b resp_val=%b, required 0 1 0",
               busy, req_rdy, resp_val);
    end
  endtask

  task automatic test_skip();
    bit ok; int lat;
    issue32(32'd3, 32'd8, ok);
    wait_resp32(lat);
    checks++;
    if (!ok || lat != (FIXED_LAT ? 33 : 3) || resp_data !== 32'd24) begin
      errors++;
      $display("FAIL skip_3x8: lat=%0d data=%0d, required lat=%0d data=24",
               lat, resp_data, FIXED_LAT ? 33 : 3);
    end
    pulse_rdy32();
  endtask

  task automatic test_all_ones();
    bit ok; int lat;
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, ok);
    wait_resp32(lat);
    checks++;
    if (!ok || lat != 33 || resp_data !== 32'd1) begin
      errors++;
      $display("FAIL all_ones: lat=%0d data=%h, required lat=33 data=1", lat, resp_data);
    end
    pulse_rdy32();
  endtask

  task automatic test_stall();
    bit ok; int lat;
    issue32(32'd7, 32'd5, ok);
    wait_resp32(lat);
    checks++;
    if (!ok || lat != (FIXED_LAT ? 33 : 4) || resp_data !== 32'd35) begin
      errors++;
      $display("FAIL stall_first: lat=%0d data=%0d, required lat=%0d data=35",
               lat, resp_data, FIXED_LAT ? 33 : 4);
    end
    for (int i = 0; i < 10; i++) begin
      req_val = 1'b1; req_a = 32'd100 + i; req_b = 32'd3;
      @(posedge clk); #1;
      checks++;
      if (resp_val !== 1'b1 || resp_data !== 32'd35 || req_rdy !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: val=%b data=%0d rdy=%b, required 1 35 0",
                 i, resp_val, resp_data, req_rdy);
      end
    end
    req_val = 1'b0;
    pulse_rdy32();
    checks++;
    if (busy !== 1'b0 || req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: busy=%b req_rdy=%b resp_val=%b, required 0 1 0",
               busy, req_rdy, resp_val);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_ignored_req: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; bit seen;
    issue32(32'd9, 32'd9, ok);
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b, required 1", busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req_rdy, resp_val, busy} !== 3'b000 || resp_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: rdy/val/busy=%b data=%h, required 000 data=0",
               {req_rdy, resp_val, busy}, resp_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_val !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_no_response: activity seen=1, required 0");
    end
    issue32(32'd2, 32'd3, ok);
    wait_resp32(lat);
    checks++;
    if (!ok || lat != (FIXED_LAT ? 33 : 3) || resp_data !== 32'd6) begin
      errors++;
      $display("FAIL mid_next_req: lat=%0d data=%0d, required lat=%0d data=6",
               lat, resp_data, FIXED_LAT ? 33 : 3);
    end
    pulse_rdy32();
  endtask

  task automatic test_back_to_back();
    bit ok; int lat;
    resp_rdy = 1'b1;
    issue32(32'd6, 32'd7, ok);
    wait_resp32(lat);
    checks++;
    if (!ok || lat != (FIXED_LAT ? 33 : 4) || resp_data !== 32'd42) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d data=%0d, required lat=%0d data=42",
               lat, resp_data, FIXED_LAT ? 33 : 4);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_same_cycle_hs: busy=%b req_rdy=%b, required 0 1", busy, req_rdy);
    end
    issue32(32'd10, 32'd12, ok);
    wait_resp32(lat);
    checks++;
    if (!ok || lat != (FIXED_LAT ? 33 : 4) || resp_data !== 32'd120) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d data=%0d, required lat=%0d data=120",
               lat, resp_data, FIXED_LAT ? 33 : 4);
    end
    @(posedge clk); #1;
    resp_rdy = 1'b0;
  endtask

  task automatic test_narrow();
    bit ok; int lat;
    issue8(8'd3, 8'h80, ok);
    wait_resp8(lat);
    checks++;
    if (!ok || lat != (FIXED_LAT ? 9 : 5) || n_resp_data !== 8'h80) begin
      errors++;
      $display("FAIL narrow_skip_cap: lat=%0d data=%h, required lat=%0d data=80",
               lat, n_resp_data, FIXED_LAT ? 9 : 5);
    end
    n_resp_rdy = 1'b1; @(posedge clk); #1; n_resp_rdy = 1'b0;
    issue8(8'hFF, 8'hFF, ok);
    wait_resp8(lat);
    checks++;
    if (!ok || lat != 9 || n_resp_data !== 8'h01) begin
      errors++;
      $display("FAIL narrow_all_ones: lat=%0d data=%h, required lat=9 data=01",
               lat, n_resp_data);
    end
    n_resp_rdy = 1'b1; @(posedge clk); #1; n_resp_rdy = 1'b0;
  endtask

  task automatic test_random32();
    bit ok; bit got; logic [31:0] a, b, expv, d; logic v; int cyc;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      case (i % 3)
        0: b = $urandom;
        1: b = $urandom & 32'h8001_0010;
        default: b = 32'h0;
      endcase
      expv = a * b;
      issue32(a, b, ok);
      got = 1'b0; cyc = 0; d = 32'h0;
      while (!got && cyc < 300) begin
        resp_rdy = 1'($urandom_range(0, 1));
        v = resp_val; d = resp_data;
        @(posedge clk); #1; cyc++;
        if (v && resp_rdy) got = 1'b1;
      end
      resp_rdy = 1'b0;
      checks++;
      if (!ok || !got || d !== expv) begin
        errors++;
        $display("FAIL rand32[%0d]: a=%h b=%h got=%0d data=%h, required %h",
                 i, a, b, got, d, expv);
      end
    end
  endtask

  task automatic test_random8();
    bit ok; bit got; logic [7:0] a, b, expv, d; logic v; int cyc;
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom);
      case (i % 3)
        0: b = 8'($urandom);
        1: b = 8'($urandom) & 8'h91;
        default: b = 8'h0;
      endcase
      expv = a * b;
      issue8(a, b, ok);
      got = 1'b0; cyc = 0; d = 8'h0;
      while (!got && cyc < 300) begin
        n_resp_rdy = 1'($urandom_range(0, 1));
        v = n_resp_val; d = n_resp_data;
        @(posedge clk); #1; cyc++;
        if (v && n_resp_rdy) got = 1'b1;
      end
      n_resp_rdy = 1'b0;
      checks++;
      if (!ok || !got || d !== expv) begin
        errors++;
        $display("FAIL rand8[%0d]: a=%h b=%h got=%0d data=%h, required %h",
                 i, a, b, got, d, expv);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_val = 1'b0; req_a = 32'h0; req_b = 32'h0; resp_rdy = 1'b0;
    n_req_val = 1'b0; n_req_a = 8'h0; n_req_b = 8'h0; n_resp_rdy = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_zero_b();
    test_skip();
    test_all_ones();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_narrow();
    test_random32();
    test_random8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
